// File: rtl/selftrigger_threshold_peak_pkg.sv
// Shared types and defaults for the threshold self-trigger stage.
// Sample width, FSM encoding and default tuning live here.
package selftrigger_threshold_peak_pkg;

  localparam int unsigned SAMPLE_W    = 16;
  localparam int unsigned HYST_DEF    = 16;
  localparam int unsigned HOLDOFF_DEF = 256;
  localparam int unsigned MAX_LEN_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_ABOVE   = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_e;

  function automatic logic signed [SAMPLE_W:0] sext17(
    input logic signed [SAMPLE_W-1:0] v
  );
    return {v[SAMPLE_W-1], v};
  endfunction

endpackage

// File: rtl/selftrigger_threshold_peak.sv
// Threshold self-trigger with hysteresis, peak tracking,
// forced trigger on over-long pulses and a hold-off window.
module selftrigger_threshold_peak
  import selftrigger_threshold_peak_pkg::*;
#(
  parameter int unsigned HYST    = HYST_DEF,
  parameter int unsigned HOLDOFF = HOLDOFF_DEF,
  parameter int unsigned MAX_LEN = MAX_LEN_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic signed [15:0] y_in,
  input  logic signed [15:0] threshold,
  output logic               trigger,
  output logic signed [15:0] peak_amp,
  output logic        [7:0]  peak_dly,
  output logic               overflow,
  output logic        [15:0] trig_count,
  output logic               busy
);

  logic               en_q;
  logic signed [15:0] y_q, thr_q;
  state_e             state_q, state_d;
  logic signed [15:0] pk_q, pk_d;
  logic        [7:0]  pk_dly_q, pk_dly_d;
  logic        [7:0]  len_q, len_d;
  logic        [15:0] ho_q, ho_d;
  logic               trig_q, trig_d;
  logic signed [15:0] amp_q, amp_d;
  logic        [7:0]  dly_q, dly_d;
  logic               ovf_q, ovf_d;
  logic        [15:0] cnt_q, cnt_d;
  logic               busy_q, busy_d;

  logic signed [16:0] y17, thr17, lvl;
  logic        [7:0]  len_inc;
  logic        [15:0] ho_inc;
  logic               fire;

  // 17-bit arm level so thr - HYST never wraps
  assign y17     = sext17(y_q);
  assign thr17   = sext17(thr_q);
  assign lvl     = thr17 - 17'(HYST);
  assign len_inc = len_q + 8'd1;
  assign ho_inc  = ho_q + 16'd1;

  always_comb begin
    state_d  = state_q;
    pk_d     = pk_q;
    pk_dly_d = pk_dly_q;
    len_d    = len_q;
    ho_d     = ho_q;
    amp_d    = amp_q;
    dly_d    = dly_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    fire     = 1'b0;
    if (en_q) begin
      unique case (state_q)
        ST_IDLE: begin
          if (y17 < lvl) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (y17 > thr17) begin
            state_d  = ST_ABOVE;
            pk_d     = y_q;
            pk_dly_d = 8'd0;
            len_d    = 8'd0;
          end
        end
        ST_ABOVE: begin
          len_d = len_inc;
          if (y_q > pk_q) begin
            pk_d     = y_q;
            pk_dly_d = len_inc;
          end
          if (y17 < lvl) begin
            fire  = 1'b1;
            ovf_d = 1'b0;
          end else if (len_inc == 8'(MAX_LEN)) begin
            fire  = 1'b1;
            ovf_d = 1'b1;
          end
          if (fire) begin
            state_d = ST_HOLDOFF;
            ho_d    = 16'd0;
            amp_d   = pk_d;
            dly_d   = pk_dly_d;
            cnt_d   = cnt_q + 16'd1;
          end
        end
        ST_HOLDOFF: begin
          ho_d = ho_inc;
          if (ho_inc == 16'(HOLDOFF)) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    trig_d = fire;
    busy_d = (state_d == ST_ABOVE) ||
             (state_d == ST_HOLDOFF);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q     <= 1'b0;
      y_q      <= '0;
      thr_q    <= '0;
      state_q  <= ST_IDLE;
      pk_q     <= '0;
      pk_dly_q <= '0;
      len_q    <= '0;
      ho_q     <= '0;
      trig_q   <= 1'b0;
      amp_q    <= '0;
      dly_q    <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      en_q <= enable;
      if (enable) begin
        y_q   <= y_in;
        thr_q <= threshold;
      end
      state_q  <= state_d;
      pk_q     <= pk_d;
      pk_dly_q <= pk_dly_d;
      len_q    <= len_d;
      ho_q     <= ho_d;
      trig_q   <= trig_d;
      amp_q    <= amp_d;
      dly_q    <= dly_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign trigger    = trig_q;
  assign peak_amp   = amp_q;
  assign peak_dly   = dly_q;
  assign overflow   = ovf_q;
  assign trig_count = cnt_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_selftrigger_threshold_peak.sv
// Directed bench for selftrigger_threshold_peak.
// HYST=16, HOLDOFF=8, MAX_LEN=10, threshold fixed at 100.
module tb_selftrigger_threshold_peak;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               enable = 1'b0;
  logic signed [15:0] y_in = '0;
  logic signed [15:0] threshold = 16'sd100;
  logic               trigger;
  logic signed [15:0] peak_amp;
  logic        [7:0]  peak_dly;
  logic               overflow;
  logic        [15:0] trig_count;
  logic               busy;

  int n_tests = 0;
  int n_fail  = 0;
  int stp, trig_n, trig_stp;
  int c_amp, c_dly, c_ovf, c_cnt;
  logic busy_s;

  selftrigger_threshold_peak #(
    .HYST(16), .HOLDOFF(8), .MAX_LEN(10)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .y_in(y_in), .threshold(threshold),
    .trigger(trigger), .peak_amp(peak_amp),
    .peak_dly(peak_dly), .overflow(overflow),
    .trig_count(trig_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic step(input int y, input logic en);
    @(negedge clk);
    y_in   = 16'(y);
    enable = en;
    @(posedge clk);
    #1;
    stp++;
    if (trigger) begin
      trig_n++;
      trig_stp = stp;
      c_amp = int'(peak_amp);
      c_dly = int'(peak_dly);
      c_ovf = int'(overflow);
      c_cnt = int'(trig_count);
    end
    busy_s = busy;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    enable = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic begin_scn();
    stp = -1; trig_n = 0; trig_stp = -1;
    c_amp = -1; c_dly = -1; c_ovf = -1; c_cnt = -1;
  endtask

  int seq1 [9] = '{0, 0, 50, 120, 180, 150, 90, 80, 0};
  int seqh [6] = '{0, 101, 90, 101, 84, 83};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_trigger", int'(trigger), 0);
    check("rst_amp", int'(peak_amp), 0);
    check("rst_dly", int'(peak_dly), 0);
    check("rst_ovf", int'(overflow), 0);
    check("rst_cnt", int'(trig_count), 0);
    check("rst_busy", int'(busy), 0);

    // arm and fire
    begin_scn();
    for (int i = 0; i < 9; i++) begin
      step(seq1[i], 1'b1);
      if (i == 3) check("s1_busy_pre", int'(busy_s), 0);
      if (i == 4) check("s1_busy_up", int'(busy_s), 1);
    end
    check("s1_ntrig", trig_n, 1);
    check("s1_when", trig_stp, 8);
    check("s1_amp", c_amp, 180);
    check("s1_dly", c_dly, 1);
    check("s1_ovf", c_ovf, 0);
    check("s1_cnt", c_cnt, 1);
    step(0, 1'b1);
    check("s1_onecyc", int'(trigger), 0);
    check("s1_amp_hold", int'(peak_amp), 180);

    // hysteresis
    do_reset();
    begin_scn();
    for (int i = 0; i < 6; i++) step(seqh[i], 1'b1);
    check("hy_noend", trig_n, 0);
    step(0, 1'b1);
    check("hy_ntrig", trig_n, 1);
    check("hy_amp", c_amp, 101);
    check("hy_dly", c_dly, 0);

    // hold-off
    do_reset();
    begin_scn();
    for (int i = 0; i < 19; i++) begin
      step((i == 1) ? 200 : (i == 6) ? 200 :
           (i == 15) ? 300 : 0, 1'b1);
      if (i == 7)  check("ho_busy", int'(busy_s), 1);
      if (i == 13) check("ho_idle", int'(busy_s), 0);
      if (i == 14) check("ho_single", trig_n, 1);
    end
    check("ho_ntrig", trig_n, 2);
    check("ho_when", trig_stp, 17);
    check("ho_cnt", c_cnt, 2);
    check("ho_amp", c_amp, 300);

    // max length
    do_reset();
    begin_scn();
    for (int i = 0; i < 41; i++) step((i == 0) ? 0 : 500, 1'b1);
    check("ml_ntrig", trig_n, 1);
    check("ml_when", trig_stp, 12);
    check("ml_ovf", c_ovf, 1);
    check("ml_amp", c_amp, 500);
    check("ml_dly", c_dly, 0);
    check("ml_busy", int'(busy_s), 0);

    // enable gating
    do_reset();
    begin_scn();
    for (int i = 0; i < 9; i++) begin
      step(seq1[i], 1'b1);
      step(32000, 1'b0);
    end
    check("en_ntrig", trig_n, 1);
    check("en_when", trig_stp, 15);
    check("en_amp", c_amp, 180);
    check("en_dly", c_dly, 1);
    check("en_ovf", c_ovf, 0);
    check("en_cnt", c_cnt, 1);
    for (int i = 0; i < 12; i++) begin
      step(0, 1'b1);
      step(32000, 1'b0);
    end

    // reset mid-pulse
    begin_scn();
    step(0, 1'b1);
    step(120, 1'b1);
    step(180, 1'b1);
    check("rm_busy", int'(busy_s), 1);
    do_reset();
    check("rm_trigger", int'(trigger), 0);
    check("rm_amp", int'(peak_amp), 0);
    check("rm_dly", int'(peak_dly), 0);
    check("rm_ovf", int'(overflow), 0);
    check("rm_cnt", int'(trig_count), 0);
    check("rm_busy0", int'(busy), 0);
    for (int i = 0; i < 4; i++) step((i == 0) ? 80 : 0, 1'b1);
    check("rm_ntrig", trig_n, 0);
    check("rm_idle", int'(busy_s), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
